phy_start_scheduler: RTL and testbench

//  Shares the PHY transmit-start path between N_REQ frame sources.
//  - Picks one requester round-robin and issues a 1-cycle start pulse plus a stretched start window.
//  - Holds the grant until the frame completes, then enforces an inter-frame gap.
//  - Sits between the MAC-side frame sources and the PHY TX datapath.

---
 rtl/phy_start_scheduler_pkg.sv | 21 ++
 rtl/phy_start_scheduler_if.sv | 28 ++
 rtl/phy_start_scheduler_rr_pick.sv | 33 +++
 rtl/phy_start_scheduler.sv | 158 +++++++++++++++
 tb/tb_phy_start_scheduler.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/phy_start_scheduler_pkg.sv
// Shared types and sizing helpers for the PHY transmit-start scheduler.
package phy_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WINDOW,
        WAIT_DONE,
        GUARD
    } state_t;

    localparam int unsigned N_REQ_DEF = 4;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned IDX_W_DEF = idx_width(N_REQ_DEF);

endpackage

// File: rtl/phy_start_scheduler_if.sv
// Request/grant bundle between MAC-side frame sources and the start scheduler.
interface phy_start_scheduler_if
    import phy_ctrl_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned IDX_W = idx_width(N_REQ)
);

    logic [N_REQ-1:0] req;
    logic             tx_done;
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             start_pulse;
    logic             start_window;
    logic             busy;
    logic             timeout_err;

    modport master (
        output req, tx_done,
        input  grant, grant_idx, start_pulse, start_window, busy, timeout_err
    );

    modport slave (
        input  req, tx_done,
        output grant, grant_idx, start_pulse, start_window, busy, timeout_err
    );

endinterface

// File: rtl/phy_start_scheduler_rr_pick.sv
// Combinational round-robin selector: first set request at or after rr_ptr, wrapping.
module rr_pick
    import phy_ctrl_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    int unsigned pos;

    // Scan N_REQ positions starting at rr_ptr; the first hit wins.
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        pos    = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            pos = (32'(rr_ptr) + i) % N_REQ;
            if (!found && req[pos]) begin
                found       = 1'b1;
                idx         = IDX_W'(pos);
                onehot[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/phy_start_scheduler.sv
// PHY transmit-start scheduler: round-robin grant, start pulse/window,
// hold until tx_done, then an inter-frame guard gap.
// Optional watchdog enabled by defining PHY_START_TIMEOUT_EN.
module phy_start_scheduler
    import phy_ctrl_pkg::*;
#(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned HOLD_CYCLES    = 58,
    parameter int unsigned GAP_CYCLES     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input logic                  clk,
    input logic                  rst,
    phy_start_scheduler_if.slave bus
);

    localparam int unsigned IDX_W = idx_width(N_REQ);
    // Counters never need to go past the longest interval the block measures.
    localparam int unsigned CNT_CEIL_I =
        (HOLD_CYCLES >= GAP_CYCLES && HOLD_CYCLES >= TIMEOUT_CYCLES) ? HOLD_CYCLES :
        (GAP_CYCLES >= TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam logic [CNT_W-1:0] CNT_CEIL = CNT_W'(CNT_CEIL_I);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_CEIL) ? v : v + 1'b1;
    endfunction

    state_t           state;
    state_t           state_n;
    logic [IDX_W-1:0] rr_ptr;
    logic [CNT_W-1:0] phase_cnt;
    logic             done_lat;
    logic             done_seen;
    logic             wd_expired;
    logic             timeout_hit;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_onehot;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

`ifdef PHY_START_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] wd_cnt;

    // Watchdog: 1 in the START cycle, counts through WINDOW/WAIT_DONE, idle otherwise.
    always_ff @(posedge clk) begin
        if (rst)
            wd_cnt <= '0;
        else if (state_n == START)
            wd_cnt <= CNT_ONE;
        else if (state_n == WINDOW || state_n == WAIT_DONE)
            wd_cnt <= sat_inc(wd_cnt);
        else
            wd_cnt <= '0;
    end

    assign wd_expired = (wd_cnt >= TO_LIM);
`else
    assign wd_expired = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next-state logic; a tx_done in the final window cycle counts as latched.
    always_comb begin
        state_n     = state;
        timeout_hit = 1'b0;
        done_seen   = done_lat | bus.tx_done;
        case (state)
            IDLE: begin
                if (pick_found)
                    state_n = START;
            end
            START, WINDOW: begin
                if (wd_expired && !done_seen) begin
                    state_n     = GUARD;
                    timeout_hit = 1'b1;
                end else if (phase_cnt >= HOLD_LIM)
                    state_n = done_seen ? GUARD : WAIT_DONE;
                else
                    state_n = WINDOW;
            end
            WAIT_DONE: begin
                if (bus.tx_done)
                    state_n = GUARD;
                else if (wd_expired) begin
                    state_n     = GUARD;
                    timeout_hit = 1'b1;
                end
            end
            GUARD: begin
                if (phase_cnt >= GAP_LIM)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Grant capture, rr pointer, shared window/gap counter, done latch, registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr           <= '0;
            phase_cnt        <= '0;
            done_lat         <= 1'b0;
            bus.grant        <= '0;
            bus.grant_idx    <= '0;
            bus.start_pulse  <= 1'b0;
            bus.start_window <= 1'b0;
            bus.busy         <= 1'b0;
            bus.timeout_err  <= 1'b0;
        end else begin
            if (state == IDLE && pick_found) begin
                bus.grant     <= pick_onehot;
                bus.grant_idx <= pick_idx;
                rr_ptr        <= (pick_idx == IDX_LAST) ? '0 : pick_idx + 1'b1;
            end else if (state_n == GUARD || state_n == IDLE) begin
                bus.grant <= '0;
            end

            if (state_n == START || (state_n == GUARD && state != GUARD))
                phase_cnt <= CNT_ONE;
            else if (state_n == WINDOW || state_n == GUARD)
                phase_cnt <= sat_inc(phase_cnt);

            if (state == START || state == WINDOW)
                done_lat <= done_lat | bus.tx_done;
            else
                done_lat <= 1'b0;

            bus.start_pulse  <= (state_n == START);
            bus.start_window <= (state_n == START) || (state_n == WINDOW);
            bus.busy         <= (state_n != IDLE);
            bus.timeout_err  <= timeout_hit;
        end
    end

endmodule

// File: tb/tb_phy_start_scheduler.sv
// Directed self-checking bench for phy_start_scheduler (N_REQ=4, HOLD=58, GAP=8).
// Build with PHY_START_TIMEOUT_EN defined to exercise the watchdog at TIMEOUT_CYCLES=100.
module tb_phy_start_scheduler;

    localparam int unsigned N    = 4;
    localparam int unsigned HOLD = 58;
    localparam int unsigned GAP  = 8;
`ifdef PHY_START_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 100;
`else
    localparam int unsigned TB_TIMEOUT = 1024;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    phy_start_scheduler_if #(.N_REQ(N)) bus ();

    phy_start_scheduler #(
        .N_REQ          (N),
        .HOLD_CYCLES    (HOLD),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TB_TIMEOUT),
        .CNT_W          (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called just after a start edge S. Drives tx_done to be sampled at edge S+done_at,
    // optionally drops req mid-frame, loads next_req at offset 20, and measures the frame
    // up to the next start pulse.
    task automatic frame(input int exp_idx, input int done_at, input bit drop,
                         input logic [3:0] next_req, input int exp_grant,
                         input int exp_busy, input int exp_next);
        int         win, gcyc, bcyc, bad, next_at;
        logic       p1;
        logic [3:0] oh;
        oh = 4'b0001 << exp_idx;
        check("frame_idx", 32'(bus.grant_idx), 32'(exp_idx));
        check("frame_grant", 32'(bus.grant), 32'(oh));
        check("frame_pulse", 32'(bus.start_pulse), 32'd1);
        win     = int'(bus.start_window);
        gcyc    = (bus.grant != '0) ? 1 : 0;
        bcyc    = int'(bus.busy);
        bad     = 0;
        next_at = -1;
        p1      = 1'b1;
        for (int e = 1; e <= 400 && next_at < 0; e++) begin
            if (drop && e == 3)
                bus.req = '0;
            if (e == 20)
                bus.req = next_req;
            bus.tx_done = (e == done_at);
            step;
            bus.tx_done = 1'b0;
            if (e == 1)
                p1 = bus.start_pulse;
            if (bus.start_pulse && e > 1)
                next_at = e;
            else begin
                win += int'(bus.start_window);
                bcyc += int'(bus.busy);
                if (bus.grant != '0) begin
                    gcyc++;
                    if (bus.grant != oh)
                        bad++;
                end
            end
        end
        check("pulse_one_cycle", 32'(p1), 32'd0);
        check("window_len", 32'(win), 32'd58);
        check("grant_cycles", 32'(gcyc), 32'(exp_grant));
        check("grant_stable", 32'(bad), 32'd0);
        check("busy_cycles", 32'(bcyc), 32'(exp_busy));
        check("next_start_at", 32'(next_at), 32'(exp_next));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int to_cnt, first_to, bcyc;

        // Reset held with all requests active.
        rst         = 1'b1;
        bus.req     = 4'b1111;
        bus.tx_done = 1'b0;
        repeat (3) step;
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_grant_idx", 32'(bus.grant_idx), 32'd0);
        check("rst_pulse", 32'(bus.start_pulse), 32'd0);
        check("rst_window", 32'(bus.start_window), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_timeout", 32'(bus.timeout_err), 32'd0);

        // Release: first start one cycle later, round-robin 0,1,3,0 with tx_done 10 in.
        rst     = 1'b0;
        bus.req = 4'b1011;
        step;
        check("release_pulse", 32'(bus.start_pulse), 32'd1);
        frame(0, 10, 1'b0, 4'b1011, 58, 66, 67);
        frame(1, 10, 1'b0, 4'b1011, 58, 66, 67);
        frame(3, 10, 1'b0, 4'b1011, 58, 66, 67);
        frame(0, 10, 1'b0, 4'b0100, 58, 66, 67);

        // Single requester, late tx_done at 70, req dropped mid-frame: grant held to done.
        frame(2, 70, 1'b1, 4'b0100, 70, 78, 79);

        // Early tx_done at 5: latched, full window, straight to GUARD.
        frame(2, 5, 1'b0, 4'b0100, 58, 66, 67);

        // Mid-frame reset: rr pointer was 3, so req 1001 would pick 3 without the reset.
        bus.req = 4'b1001;
        repeat (10) step;
        check("pre_rst_window", 32'(bus.start_window), 32'd1);
        rst = 1'b1;
        step;
        check("midrst_grant", 32'(bus.grant), 32'd0);
        check("midrst_window", 32'(bus.start_window), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_pulse", 32'(bus.start_pulse), 32'd0);
        rst = 1'b0;
        step;
        check("post_rst_pulse", 32'(bus.start_pulse), 32'd1);
        check("post_rst_idx", 32'(bus.grant_idx), 32'd0);
        check("post_rst_grant", 32'(bus.grant), 32'd1);

        // No tx_done ever: watchdog abort, or indefinite wait without it.
        bus.req  = '0;
        to_cnt   = 0;
        first_to = -1;
        bcyc     = int'(bus.busy);
        for (int e = 1; e <= 2000; e++) begin
            step;
            if (bus.timeout_err) begin
                to_cnt++;
                if (first_to < 0)
                    first_to = e;
            end
            bcyc += int'(bus.busy);
        end
`ifdef PHY_START_TIMEOUT_EN
        check("timeout_at", 32'(first_to), 32'd100);
        check("timeout_pulses", 32'(to_cnt), 32'd1);
        check("timeout_busy_cycles", 32'(bcyc), 32'd108);
        check("timeout_end_grant", 32'(bus.grant), 32'd0);
`else
        check("no_timeout_at", 32'(first_to), 32'hFFFF_FFFF);
        check("no_timeout_pulses", 32'(to_cnt), 32'd0);
        check("no_timeout_busy_cycles", 32'(bcyc), 32'd2001);
        check("no_timeout_grant", 32'(bus.grant), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
